reg_write_arbiter: RTL and testbench



---
 rtl/reg_write_arbiter.sv | 100 ++++++++++
 tb/tb_reg_write_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one store-enabled register among NREQ requesters.
// Each grant runs IDLE -> ISSUE (store strobe) -> COMMIT (one-hot ack).
module reg_write_arbiter #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned NREQ  = 4,
   localparam int unsigned IdW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                  cl,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] wdata,
   output logic                  st,
   output logic [WIDTH-1:0]      d,
   output logic [NREQ-1:0]       ack,
   output logic [IdW-1:0]        grant_id,
   output logic                  busy
);

   typedef enum logic [1:0] {StIdle, StIssue, StCommit} state_e;

   state_e           state_q, state_d;
   logic [IdW-1:0]   ptr_q, ptr_d;
   logic [IdW-1:0]   grant_q, grant_d;
   logic [NREQ-1:0]  last_mask_q, last_mask_d;
   logic [WIDTH-1:0] d_q, d_d;

   logic [NREQ-1:0]  eff_req;
   logic             found;
   logic [IdW-1:0]   winner;

   // First set bit of the masked request vector, searching upward from ptr with wrap.
   always_comb begin
      logic [IdW-1:0] cand;
      eff_req = req & ~last_mask_q;
      found   = 1'b0;
      winner  = '0;
      cand    = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         cand = IdW'((32'(ptr_q) + i) % NREQ);
         if (!found && eff_req[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      grant_d     = grant_q;
      last_mask_d = last_mask_q;
      d_d         = d_q;
      unique case (state_q)
         StIdle: begin
            last_mask_d = '0;
            if (found) begin
               state_d = StIssue;
               grant_d = winner;
               d_d     = wdata[32'(winner)*WIDTH +: WIDTH];
            end
         end
         StIssue: begin
            state_d = StCommit;
         end
         StCommit: begin
            ptr_d       = (grant_q == IdW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
            // Masks the acked requester's stale level during the following IDLE cycle.
            last_mask_d = NREQ'(1) << grant_q;
            state_d     = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge cl or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         ptr_q       <= '0;
         grant_q     <= '0;
         last_mask_q <= '0;
         d_q         <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         grant_q     <= grant_d;
         last_mask_q <= last_mask_d;
         d_q         <= d_d;
      end
   end

   // Outputs decode registered state only, so reset clears them asynchronously.
   assign st       = (state_q == StIssue);
   assign busy     = (state_q != StIdle);
   assign ack      = (state_q == StCommit) ? (NREQ'(1) << grant_q) : '0;
   assign d        = d_q;
   assign grant_id = grant_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: vector table of single grants plus
// hand-written sequences for stale masking, data isolation, reset and rotation.
module tb_reg_write_arbiter;

   logic        cl;
   logic        rst_n;
   logic [3:0]  req;
   logic [63:0] wdata;
   logic        st;
   logic [15:0] d;
   logic [3:0]  ack;
   logic [1:0]  grant_id;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;

   reg_write_arbiter #(
      .WIDTH (16),
      .NREQ  (4)
   ) dut (
      .cl       (cl),
      .rst_n    (rst_n),
      .req      (req),
      .wdata    (wdata),
      .st       (st),
      .d        (d),
      .ack      (ack),
      .grant_id (grant_id),
      .busy     (busy)
   );

   initial cl = 1'b0;
   always #5 cl = ~cl;

   typedef struct {
      logic [3:0]  req;
      logic [63:0] wdata;
      logic [1:0]  gnt;
      logic [15:0] dexp;
   } vec_t;

   vec_t       vecs[8];
   logic [3:0] oh;
   logic [3:0] raise;
   int         got[$];
   int         stc[$];
   int         exp_rot[5];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      // Hand-computed sequence; ptr/last_mask carry over between entries.
      vecs[0] = '{4'b0100, 64'h1111_BEEF_3333_4444, 2'd2, 16'hBEEF};
      vecs[1] = '{4'b1001, 64'hD003_D002_D001_D000, 2'd3, 16'hD003};
      vecs[2] = '{4'b1001, 64'hC3C3_C2C2_C1C1_C0C0, 2'd0, 16'hC0C0};
      vecs[3] = '{4'b1111, 64'h0123_4567_89AB_CDEF, 2'd1, 16'h89AB};
      vecs[4] = '{4'b1111, 64'hFFFF_0000_AAAA_5555, 2'd2, 16'h0000};
      vecs[5] = '{4'b0011, 64'h1234_5678_9ABC_DEF0, 2'd0, 16'hDEF0};
      vecs[6] = '{4'b0110, 64'hAAAA_BBBB_CCCC_DDDD, 2'd1, 16'hCCCC};
      vecs[7] = '{4'b1010, 64'h0F0F_F0F0_3C3C_C3C3, 2'd3, 16'h0F0F};
      exp_rot = '{0, 1, 2, 3, 0};

      rst_n = 1'b0;
      req   = '0;
      wdata = '0;
      #1;
      check("rst_st", st, 0);
      check("rst_d", d, 0);
      check("rst_ack", ack, 0);
      check("rst_grant_id", grant_id, 0);
      check("rst_busy", busy, 0);
      @(negedge cl);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         req   = vecs[i].req;
         wdata = vecs[i].wdata;
         @(negedge cl);
         check($sformatf("v%0d_issue_st", i), st, 1);
         check($sformatf("v%0d_issue_d", i), d, vecs[i].dexp);
         check($sformatf("v%0d_grant_id", i), grant_id, vecs[i].gnt);
         check($sformatf("v%0d_issue_ack", i), ack, 0);
         @(negedge cl);
         oh = 4'b0001 << vecs[i].gnt;
         check($sformatf("v%0d_commit_ack", i), ack, oh);
         check($sformatf("v%0d_commit_st", i), st, 0);
         check($sformatf("v%0d_commit_busy", i), busy, 1);
         req = '0;
         @(negedge cl);
         check($sformatf("v%0d_idle_busy", i), busy, 0);
         check($sformatf("v%0d_idle_st", i), st, 0);
      end

      // Stale request: req[1] held one edge past its ack must not be re-granted.
      req = 4'b0010;
      @(negedge cl);
      check("stale_st", st, 1);
      check("stale_gnt", grant_id, 1);
      check("stale_d", d, 16'h3C3C);
      @(negedge cl);
      check("stale_ack", ack, 4'b0010);
      @(negedge cl);
      check("stale_idle1", busy, 0);
      @(negedge cl);
      check("stale_masked_busy", busy, 0);
      check("stale_masked_st", st, 0);
      req = '0;
      @(negedge cl);
      check("stale_idle2", busy, 0);
      req = 4'b0010;
      @(negedge cl);
      check("reraise_st", st, 1);
      check("reraise_gnt", grant_id, 1);
      @(negedge cl);
      check("reraise_ack", ack, 4'b0010);
      req = '0;
      @(negedge cl);

      // Data isolation: wdata[0] changes during ISSUE, d keeps the latched value.
      wdata        = '0;
      wdata[15:0]  = 16'h5A5A;
      req          = 4'b0001;
      @(negedge cl);
      check("iso_st", st, 1);
      check("iso_gnt", grant_id, 0);
      check("iso_d_issue", d, 16'h5A5A);
      wdata[15:0] = 16'hFFFF;
      @(negedge cl);
      check("iso_ack", ack, 4'b0001);
      check("iso_d_commit", d, 16'h5A5A);
      req = '0;
      @(negedge cl);
      check("iso_d_idle", d, 16'h5A5A);

      // Reset mid-ISSUE clears outputs without a clock edge.
      req = 4'b1111;
      @(negedge cl);
      check("rmid_st_before", st, 1);
      #2 rst_n = 1'b0;
      #1;
      check("rmid_st", st, 0);
      check("rmid_busy", busy, 0);
      check("rmid_ack", ack, 0);
      check("rmid_grant_id", grant_id, 0);
      check("rmid_d", d, 0);
      @(negedge cl);
      check("rmid_hold_st", st, 0);
      check("rmid_hold_ack", ack, 0);
      rst_n = 1'b1;

      // Rotation: all requesting, each drops on ack and re-raises one cycle later.
      raise = '0;
      for (int c = 0; c < 30 && got.size() < 5; c++) begin
         @(negedge cl);
         req   = req | raise;
         raise = '0;
         if (st) stc.push_back(c);
         if (ack != 4'b0000) begin
            for (int j = 0; j < 4; j++) if (ack[j]) got.push_back(j);
            raise = ack;
            req   = req & ~ack;
         end
      end
      check("rot_ack_count", 64'(got.size()), 5);
      check("rot_st_count", 64'(stc.size()), 5);
      for (int k = 0; k < got.size() && k < 5; k++)
         check($sformatf("rot_ack%0d", k), 64'(got[k]), 64'(exp_rot[k]));
      for (int k = 1; k < stc.size(); k++)
         check($sformatf("rot_st_spacing%0d", k), 64'(stc[k] - stc[k-1]), 3);

      req = '0;
      repeat (4) @(negedge cl);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
